wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the single register-file write port behind the MEM/WB pipeline register. Arbitrates it between
//  the in-order WB stage (always wins) and a long-latency result source (multi-cycle mul/div, late load
//  return), buffering deferred results in-order. Keeps a per-register scoreboard so the hazard unit can
//  stall issue of instructions that touch registers still in flight.
// PARAMETERS
//  DATA_W  32  register / result data width
//  REG_W   5   register index width (2**REG_W architectural regs, x0 hardwired zero)
//  DEPTH   4   pending-result FIFO entries (power of two, >=2)
// PORTS
//  clk          in   1         core clock, all state on rising edge
//  rstn         in   1         asynchronous active-low reset
//  wb_rd_data   in   DATA_W    ALU/EX result from MEM/WB
//  wb_dm_out    in   DATA_W    data-memory load data from MEM/WB
//  wb_rd_addr   in   REG_W     WB destination register
//  wb_reg_wr    in   1         WB stage requests a register write
//  wb_dm2reg    in   1         1: write wb_dm_out, 0: write wb_rd_data
//  lat_valid    in   1         long-latency result valid
//  lat_ready    out  1         block accepts lat result this cycle
//  lat_rd_addr  in   REG_W     long-latency destination
//  lat_data     in   DATA_W    long-latency result
//  issue_valid  in   1         long-latency op issuing this cycle
//  issue_rd     in   REG_W     its destination register
//  issue_stall  out  1         issue_valid & busy_mask[issue_rd] (WAW block), combinational
//  busy_mask    out  2**REG_W  registered scoreboard, bit i = reg i has an outstanding result
//  rf_we        out  1         registered regfile write enable
//  rf_waddr     out  REG_W     registered write address
//  rf_wdata     out  DATA_W    registered write data
//  pend_cnt     out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset (rstn=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, FIFO emptied, pend_cnt=0;
//    an in-flight lat result or issue on the reset edge is discarded.
//  - Write port latency 1: source selected in cycle N appears on rf_* after the edge ending N.
//  - Selection priority per cycle: (1) WB when wb_reg_wr & wb_rd_addr!=0; (2) FIFO head when non-empty;
//    (3) lat input direct when lat_valid & lat_ready & FIFO empty (bypass, not enqueued). None: rf_we=0.
//  - Writes to x0 from any source: rf_we=0; a lat result for x0 is accepted and dropped.
//  - lat_ready = (pend_cnt < DEPTH); not dependent on lat_valid. Accepted lat result not written
//    this cycle is pushed to FIFO tail. Full FIFO: lat_ready=0, producer holds data stable.
//  - FIFO strictly in-order; pop only when FIFO head is the selected source. Push+pop same cycle:
//    pend_cnt unchanged. Pointers wrap modulo DEPTH.
//  - Scoreboard: issue_valid & !issue_stall & issue_rd!=0 sets bit; a lat-sourced write (FIFO pop or
//    bypass) clears bit of its rd on the same edge rf_we rises. Set and clear of same reg same cycle:
//    set wins. WB-sourced writes never touch busy_mask.
//  - Upstream hazard unit uses busy_mask to block WB writes/reads of busy regs; block does not check.
// CONFIGURATION
//  WB_FWD_EN defined: extra outputs fwd_valid/fwd_addr/fwd_data = the source selected this cycle
//    (combinational, pre-register) so EX may forward one cycle early; fwd_valid=0 for x0.
//  WB_FWD_EN undefined: those ports and logic absent; consumers see results only via regfile.
// STRUCTURE
//  Package wb_arb_pkg: DATA_W/REG_W defaults, typedef struct packed {logic[REG_W-1:0] rd;
//    logic[DATA_W-1:0] data;} wb_req_t; typedef enum logic[1:0] {SRC_NONE,SRC_WB,SRC_FIFO,SRC_LAT} wb_src_e.
//  Sub-module wb_pend_fifo: DEPTH x wb_req_t sync FIFO, push/pop/full/empty/count, async rstn.
//  Top: source-select mux, output register, scoreboard register, x0 filter.
// TESTING
//  1 WB only: reg_wr=1, rd=5, dm2reg=1, dm_out=32'hCAFE0001 -> next cycle rf_we=1, waddr=5, wdata=CAFE0001.
//  2 Bypass: WB idle, issue rd=7 then lat_valid rd=7 data=0x11 -> rf write 7/0x11 1 cycle later, busy[7] 1->0.
//  3 Collision: WB rd=3 and lat rd=9 same cycle -> cycle+1 writes x3, cycle+2 writes x9, pend_cnt 1->0.
//  4 Backpressure: WB writes every cycle, 5 lat results with DEPTH=4 -> lat_ready=0 after 4th, none lost,
//    drained in order once WB idles.
//  5 x0/WAW: lat rd=0 -> no rf_we, pend_cnt stays 0; issue rd=7 while busy[7]=1 -> issue_stall=1, mask unchanged.
//  6 Reset with pend_cnt=3, busy_mask!=0: rstn low mid-cycle -> all outputs 0 immediately, no writes after release.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Package for the register-file write-port arbiter.
// Holds the default data/register widths, the deferred-result record
// stored in the pending FIFO, and the write-source encoding used by the
// top-level source-select mux.
package wb_arb_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_REG_W  = 5;
    localparam int ARB_DEPTH  = 4;

    // One deferred long-latency result: destination register plus data.
    typedef struct packed {
        logic [ARB_REG_W-1:0]  rd;
        logic [ARB_DATA_W-1:0] data;
    } wb_req_t;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_LAT  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for deferred long-latency results.
// DEPTH entries of wb_req_t, strictly in-order, synchronous push/pop with
// asynchronous active-low reset. Pointers wrap naturally because DEPTH is
// a power of two. Push while full and pop while empty are ignored.
// Ports:
//   clk, rstn    clock / async active-low reset
//   push, wr_req enqueue wr_req at the tail
//   pop          dequeue the head
//   head         current head entry (valid when !empty)
//   full, empty  occupancy flags
//   count        occupancy, 0..DEPTH
module wb_pend_fifo
    import wb_arb_pkg::*;
#(
    parameter  int DEPTH = ARB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  wb_req_t          wr_req,
    input  logic             pop,
    output wb_req_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_req_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (cnt_r == DEPTH_C);
    assign empty  = (cnt_r == {CNT_W{1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign head   = mem_r[rd_ptr_r];
    assign count  = cnt_r;

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_req;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter behind the MEM/WB pipeline register.
// The in-order WB stage always wins the single write port; long-latency
// results (mul/div, late loads) either bypass straight to the port when it
// is free or wait in an in-order pending FIFO. A per-register scoreboard
// (busy_mask) tracks long-latency destinations still in flight.
// Optional feature macro: WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data,
// the pre-register view of this cycle's selected write for early forwarding.
// Ports:
//   clk, rstn                 clock / async active-low reset
//   wb_*                      WB-stage write request (ALU or load data)
//   lat_valid/ready/rd/data   long-latency result handshake
//   issue_valid/rd, stall     long-latency issue and WAW block
//   busy_mask                 registered scoreboard
//   rf_we/waddr/wdata         registered regfile write port
//   pend_cnt                  pending FIFO occupancy
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int DATA_W = ARB_DATA_W,
    parameter  int REG_W  = ARB_REG_W,
    parameter  int DEPTH  = ARB_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int NREG   = 2 ** REG_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] wb_rd_data,
    input  logic [DATA_W-1:0] wb_dm_out,
    input  logic [REG_W-1:0]  wb_rd_addr,
    input  logic              wb_reg_wr,
    input  logic              wb_dm2reg,
    input  logic              lat_valid,
    output logic              lat_ready,
    input  logic [REG_W-1:0]  lat_rd_addr,
    input  logic [DATA_W-1:0] lat_data,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rd,
    output logic              issue_stall,
    output logic [NREG-1:0]   busy_mask,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  pend_cnt
`ifdef WB_FWD_EN
   ,output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam logic [REG_W-1:0] X0 = {REG_W{1'b0}};

    wb_src_e           src_s;
    wb_req_t           head_s;
    wb_req_t           lat_req_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [CNT_W-1:0]  fifo_cnt_s;
    logic              wb_hit_s;
    logic              lat_acc_s;
    logic              push_s;
    logic              pop_s;
    logic [REG_W-1:0]  sel_rd_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_we_s;
    logic              lat_src_s;
    logic [NREG-1:0]   busy_nxt_s;
    logic [NREG-1:0]   busy_r;
    logic              rf_we_r;
    logic [REG_W-1:0]  rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;

    // A WB write to x0 does not claim the port, so a pending result can use it.
    assign wb_hit_s  = wb_reg_wr && (wb_rd_addr != X0);
    assign lat_ready = !fifo_full_s;
    assign lat_acc_s = lat_valid && lat_ready;
    assign lat_req_s = '{rd: lat_rd_addr, data: lat_data};

    // Source priority: WB, then FIFO head, then direct bypass of the lat input.
    always_comb begin
        src_s = SRC_NONE;
        if (wb_hit_s) begin
            src_s = SRC_WB;
        end else if (!fifo_empty_s) begin
            src_s = SRC_FIFO;
        end else if (lat_acc_s) begin
            src_s = SRC_LAT;
        end else begin
            src_s = SRC_NONE;
        end
    end

    // Write-port mux for the selected source.
    always_comb begin
        sel_rd_s   = X0;
        sel_data_s = {DATA_W{1'b0}};
        case (src_s)
            SRC_WB: begin
                sel_rd_s   = wb_rd_addr;
                sel_data_s = wb_dm2reg ? wb_dm_out : wb_rd_data;
            end
            SRC_FIFO: begin
                sel_rd_s   = head_s.rd;
                sel_data_s = head_s.data;
            end
            SRC_LAT: begin
                sel_rd_s   = lat_rd_addr;
                sel_data_s = lat_data;
            end
            default: begin
                sel_rd_s   = X0;
                sel_data_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // x0 filter: a selected write to x0 never reaches the regfile.
    assign sel_we_s  = (src_s != SRC_NONE) && (sel_rd_s != X0);
    assign lat_src_s = (src_s == SRC_FIFO) || (src_s == SRC_LAT);
    assign pop_s     = (src_s == SRC_FIFO);
    // Accepted but not written now: defer it, except x0 results which are dropped.
    assign push_s    = lat_acc_s && (src_s != SRC_LAT) && (lat_rd_addr != X0);

    assign issue_stall = issue_valid && busy_r[issue_rd];

    // Scoreboard update: clear on a lat-sourced write, then set on issue so set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (lat_src_s && sel_we_s) begin
            busy_nxt_s[sel_rd_s] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (issue_valid && !issue_stall && (issue_rd != X0)) begin
            busy_nxt_s[issue_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Registered write port; address/data hold their last value when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= X0;
            rf_wdata_r <= {DATA_W{1'b0}};
        end else begin
            rf_we_r <= sel_we_s;
            if (sel_we_s) begin
                rf_waddr_r <= sel_rd_s;
                rf_wdata_r <= sel_data_s;
            end
        end
    end

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (push_s),
        .wr_req (lat_req_s),
        .pop    (pop_s),
        .head   (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_cnt_s)
    );

    assign busy_mask = busy_r;
    assign rf_we     = rf_we_r;
    assign rf_waddr  = rf_waddr_r;
    assign rf_wdata  = rf_wdata_r;
    assign pend_cnt  = fifo_cnt_s;

`ifdef WB_FWD_EN
    assign fwd_valid = sel_we_s;
    assign fwd_addr  = sel_rd_s;
    assign fwd_data  = sel_data_s;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (default build, DEPTH=4).
// A queue-based reference model of the write-port rules runs on every
// rising edge; a compare process checks the DUT against it on every
// falling edge. Directed scenarios add hand-computed literal checks.
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] wb_rd_data = 32'h0;
    logic [31:0] wb_dm_out = 32'h0;
    logic [4:0]  wb_rd_addr = 5'd0;
    logic        wb_reg_wr = 1'b0;
    logic        wb_dm2reg = 1'b0;
    logic        lat_valid = 1'b0;
    logic        lat_ready;
    logic [4:0]  lat_rd_addr = 5'd0;
    logic [31:0] lat_data = 32'h0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        issue_stall;
    logic [31:0] busy_mask;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  pend_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    ent_t        q[$];
    logic [31:0] m_busy = 32'h0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'h0;
    logic        m_acc, m_used, m_stall;
    logic [31:0] m_clr;
    ent_t        m_e;

    wb_port_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .wb_rd_data  (wb_rd_data),
        .wb_dm_out   (wb_dm_out),
        .wb_rd_addr  (wb_rd_addr),
        .wb_reg_wr   (wb_reg_wr),
        .wb_dm2reg   (wb_dm2reg),
        .lat_valid   (lat_valid),
        .lat_ready   (lat_ready),
        .lat_rd_addr (lat_rd_addr),
        .lat_data    (lat_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .busy_mask   (busy_mask),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pend_cnt    (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // inputs change 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wb_reg_wr   = 1'b0;
        wb_rd_addr  = 5'd0;
        lat_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] dm, input logic sel_dm);
        wb_reg_wr  = 1'b1;
        wb_rd_addr = rd;
        wb_rd_data = alu;
        wb_dm_out  = dm;
        wb_dm2reg  = sel_dm;
    endtask

    task automatic set_lat(input logic [4:0] rd, input logic [31:0] d);
        lat_valid   = 1'b1;
        lat_rd_addr = rd;
        lat_data    = d;
    endtask

    // Reference model: WB wins, then oldest pending, then direct lat; x0 never written.
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                q.delete();
                m_busy = 32'h0;
                m_we   = 1'b0;
                m_addr = 5'd0;
                m_data = 32'h0;
            end else begin
                m_stall = issue_valid && m_busy[issue_rd];
                m_acc   = lat_valid && (q.size() < DEPTH);
                m_used  = 1'b0;
                m_clr   = 32'h0;
                m_we    = 1'b0;
                if (wb_reg_wr && wb_rd_addr != 5'd0) begin
                    m_we   = 1'b1;
                    m_addr = wb_rd_addr;
                    m_data = wb_dm2reg ? wb_dm_out : wb_rd_data;
                end else if (q.size() > 0) begin
                    m_e    = q.pop_front();
                    m_we   = 1'b1;
                    m_addr = m_e.rd;
                    m_data = m_e.data;
                    m_clr[m_e.rd] = 1'b1;
                end else if (m_acc) begin
                    m_used = 1'b1;
                    if (lat_rd_addr != 5'd0) begin
                        m_we   = 1'b1;
                        m_addr = lat_rd_addr;
                        m_data = lat_data;
                        m_clr[lat_rd_addr] = 1'b1;
                    end
                end
                if (m_acc && !m_used && lat_rd_addr != 5'd0) begin
                    q.push_back('{rd: lat_rd_addr, data: lat_data});
                end
                m_busy = m_busy & ~m_clr;
                if (issue_valid && !m_stall && issue_rd != 5'd0) begin
                    m_busy[issue_rd] = 1'b1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle while out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("rf_we", 64'(rf_we), 64'(m_we));
                if (m_we) begin
                    chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
                    chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
                end
                chk("busy_mask", 64'(busy_mask), 64'(m_busy));
                chk("pend_cnt", 64'(pend_cnt), 64'(q.size()));
                chk("lat_ready", 64'(lat_ready), 64'(q.size() < DEPTH));
                chk("issue_stall", 64'(issue_stall), 64'(issue_valid && m_busy[issue_rd]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_busy", 64'(busy_mask), 64'd0);
        chk("reset_pend", 64'(pend_cnt), 64'd0);
        chk("reset_ready", 64'(lat_ready), 64'd1);
        rstn = 1'b1;
        step();

        // 1: WB only, load data selected
        set_wb(5'd5, 32'hDEAD0000, 32'hCAFE0001, 1'b1);
        step();
        idle();
        chk("t1_we", 64'(rf_we), 64'd1);
        chk("t1_addr", 64'(rf_waddr), 64'd5);
        chk("t1_data", 64'(rf_wdata), 64'hCAFE0001);
        step();

        // 2: issue x7, then bypass its result
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        idle();
        chk("t2_busy_set", 64'(busy_mask), 64'h80);
        set_lat(5'd7, 32'h11);
        step();
        idle();
        chk("t2_we", 64'(rf_we), 64'd1);
        chk("t2_addr", 64'(rf_waddr), 64'd7);
        chk("t2_data", 64'(rf_wdata), 64'h11);
        chk("t2_busy_clr", 64'(busy_mask), 64'h0);

        // 3: WB x3 and lat x9 collide
        set_wb(5'd3, 32'h33, 32'h0, 1'b0);
        set_lat(5'd9, 32'h99);
        step();
        idle();
        chk("t3_addr1", 64'(rf_waddr), 64'd3);
        chk("t3_data1", 64'(rf_wdata), 64'h33);
        chk("t3_pend1", 64'(pend_cnt), 64'd1);
        step();
        chk("t3_addr2", 64'(rf_waddr), 64'd9);
        chk("t3_data2", 64'(rf_wdata), 64'h99);
        chk("t3_pend2", 64'(pend_cnt), 64'd0);

        // 5: x0 results dropped, WAW stall
        set_lat(5'd0, 32'hBAD);
        step();
        idle();
        chk("t5_x0_we", 64'(rf_we), 64'd0);
        chk("t5_x0_pend", 64'(pend_cnt), 64'd0);
        set_wb(5'd2, 32'h22, 32'h0, 1'b0);
        set_lat(5'd0, 32'hBAD);
        step();
        idle();
        chk("t5_x0_pend_wb", 64'(pend_cnt), 64'd0);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        chk("t5_stall", 64'(issue_stall), 64'd1);
        step();
        idle();
        chk("t5_mask", 64'(busy_mask), 64'h80);
        set_lat(5'd7, 32'h77);
        step();
        idle();

        // 4: backpressure with WB busy every cycle
        for (int i = 0; i < 4; i++) begin
            set_wb(5'(20 + i), 32'h500 + 32'(i), 32'h0, 1'b0);
            set_lat(5'(10 + i), 32'h400 + 32'(i));
            step();
        end
        set_wb(5'd24, 32'h504, 32'h0, 1'b0);
        set_lat(5'd14, 32'h404);
        chk("t4_full_ready", 64'(lat_ready), 64'd0);
        chk("t4_full_pend", 64'(pend_cnt), 64'd4);
        step();
        step();
        chk("t4_hold_pend", 64'(pend_cnt), 64'd4);
        wb_reg_wr = 1'b0;
        n = 0;
        while (!lat_ready && n < 10) begin
            step();
            n++;
        end
        chk("t4_ready_timeout", 64'(lat_ready), 64'd1);
        step();
        lat_valid = 1'b0;
        repeat (6) step();
        chk("t4_drained", 64'(pend_cnt), 64'd0);
        chk("t4_last_addr", 64'(rf_waddr), 64'd14);
        chk("t4_last_data", 64'(rf_wdata), 64'h404);

        // 6: reset mid-cycle with pending work
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            set_wb(5'd1, 32'h100 + 32'(i), 32'h0, 1'b0);
            set_lat(5'(12 + i), 32'h600 + 32'(i));
            step();
        end
        idle();
        chk("t6_pend3", 64'(pend_cnt), 64'd3);
        chk("t6_busy", 64'(busy_mask != 32'h0), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_we", 64'(rf_we), 64'd0);
        chk("t6_rst_addr", 64'(rf_waddr), 64'd0);
        chk("t6_rst_data", 64'(rf_wdata), 64'd0);
        chk("t6_rst_busy", 64'(busy_mask), 64'd0);
        chk("t6_rst_pend", 64'(pend_cnt), 64'd0);
        step();
        step();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_write", 64'(rf_we), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
